id_stage_pipe: RTL and testbench

//  Parametrised instruction-decode stage for the 5-stage MIPS-subset pipeline.

---
 rtl/id_stage_pipe.sv | 191 +++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage of a 5-stage MIPS-subset pipeline.
//   Contains the register file, the main control decode, the load-use and branch
//   hazard unit, ID-stage beq resolution and the registered ID/EX pipeline register.
// Optional feature: define WB_BYPASS_EN so that register reads see same-cycle writeback.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid, instr, pc_next          instruction from IF/ID and its PC+4
//   hold                              downstream stall, freezes ID/EX and upstream
//   wb_we, wb_addr, wb_data           register-file write port
//   mem_rd_load, mem_wreg             load in MEM and its destination
//   pc_write, ifid_write              combinational upstream enables
//   br_taken, br_target               combinational branch redirect
//   ex_valid, ex_ctrl, ex_m, ex_wb     registered ID/EX valid and control
//   ex_rs, ex_rt, ex_wreg             registered register numbers
//   ex_data1, ex_data2, ex_imm        registered operand values and immediate
module id_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned IMM_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_next,
    input  logic            hold,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_rd_load,
    input  logic [AW-1:0]   mem_wreg,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            ex_valid,
    output logic [3:0]      ex_ctrl,
    output logic [1:0]      ex_m,
    output logic [1:0]      ex_wb,
    output logic [AW-1:0]   ex_rs,
    output logic [AW-1:0]   ex_rt,
    output logic [AW-1:0]   ex_wreg,
    output logic [XLEN-1:0] ex_data1,
    output logic [XLEN-1:0] ex_data2,
    output logic [XLEN-1:0] ex_imm
);

    localparam int unsigned NREG = 1 << AW;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;

    logic [5:0]      op;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_ext;

    assign op      = instr[31:26];
    assign rs      = AW'(instr[25:21]);
    assign rt      = AW'(instr[20:16]);
    assign rd      = AW'(instr[15:11]);
    assign imm16   = instr[15:0];
    assign imm_ext = {{(XLEN-16){imm16[15]}}, imm16};

    // Register file; r0 is never written and always reads zero.
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Two combinational read ports.
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;

    always_comb begin
        data1 = (rs == '0) ? '0 : regs[rs];
        data2 = (rt == '0) ? '0 : regs[rt];
`ifdef WB_BYPASS_EN
        if (wb_we && wb_addr == rs && rs != '0) data1 = wb_data;
        if (wb_we && wb_addr == rt && rt != '0) data2 = wb_data;
`endif
    end

    // Main control decode.
    logic          dec_ok;
    logic          dec_beq;
    logic          reads_rt;
    logic [3:0]    dec_ctrl;
    logic [1:0]    dec_m;
    logic [1:0]    dec_wb;
    logic [AW-1:0] dec_wreg;

    always_comb begin
        dec_ok   = 1'b0;
        dec_beq  = 1'b0;
        reads_rt = 1'b0;
        dec_ctrl = 4'b0000;
        dec_m    = 2'b00;
        dec_wb   = 2'b00;
        dec_wreg = '0;
        case (op)
            OP_R: begin
                dec_ok   = 1'b1;
                reads_rt = 1'b1;
                dec_ctrl = 4'b1100;
                dec_wb   = 2'b10;
                dec_wreg = rd;
            end
            OP_LW: begin
                dec_ok   = 1'b1;
                dec_ctrl = 4'b0001;
                dec_m    = 2'b10;
                dec_wb   = 2'b11;
                dec_wreg = rt;
            end
            OP_SW: begin
                dec_ok   = 1'b1;
                reads_rt = 1'b1;
                dec_ctrl = 4'b0001;
                dec_m    = 2'b01;
            end
            OP_BEQ: begin
                dec_ok   = 1'b1;
                dec_beq  = 1'b1;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection: load in EX feeding any source, or beq needing a value still in flight.
    logic load_use;
    logic br_stall;
    logic stall;

    always_comb begin
        load_use = ex_m[1] && ex_wreg != '0 &&
                   (ex_wreg == rs || (reads_rt && ex_wreg == rt));
        br_stall = dec_beq &&
                   ((ex_wb[1] && ex_wreg != '0 && (ex_wreg == rs || ex_wreg == rt)) ||
                    (mem_rd_load && mem_wreg != '0 && (mem_wreg == rs || mem_wreg == rt)));
        stall    = in_valid && (load_use || br_stall);
    end

    assign pc_write   = !hold && !stall;
    assign ifid_write = !hold && !stall;
    assign br_taken   = in_valid && dec_beq && !stall && !hold && (data1 == data2);
    assign br_target  = pc_next + (imm_ext << IMM_SHIFT);

    // ID/EX register: hold freezes it, stalls and non-instructions insert a bubble.
    logic load_ok;
    assign load_ok = in_valid && dec_ok && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_m     <= '0;
            ex_wb    <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_wreg  <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
        end else if (!hold) begin
            ex_valid <= load_ok;
            ex_ctrl  <= load_ok ? dec_ctrl : 4'b0000;
            ex_m     <= load_ok ? dec_m    : 2'b00;
            ex_wb    <= load_ok ? dec_wb   : 2'b00;
            ex_wreg  <= load_ok ? dec_wreg : '0;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_data1 <= data1;
            ex_data2 <= data2;
            ex_imm   <= imm_ext;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus randomized traffic for id_stage_pipe,
//   checked every cycle against a behavioural model of the decode stage.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc_next;
    logic        hold;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_rd_load;
    logic [4:0]  mem_wreg;
    logic        pc_write;
    logic        ifid_write;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ex_valid;
    logic [3:0]  ex_ctrl;
    logic [1:0]  ex_m;
    logic [1:0]  ex_wb;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wreg;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_imm;

    id_stage_pipe #(.XLEN(32), .AW(5), .IMM_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_next(pc_next),
        .hold(hold), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_rd_load(mem_rd_load), .mem_wreg(mem_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write), .br_taken(br_taken),
        .br_target(br_target), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_m(ex_m),
        .ex_wb(ex_wb), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [1:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
    } ex_t;

    ex_t         mex;
    logic [31:0] mregs [32];
    bit          ok = 1'b0;

    function automatic logic [31:0] mread(input logic [4:0] src);
        if (src == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_we && wb_addr == src) return wb_data;
`endif
        return mregs[src];
    endfunction

    always @(negedge clk) begin : cmp
        logic [5:0]  op;
        logic [4:0]  s, t, d;
        logic [31:0] sx, a, b, tgt;
        bit          is_r, is_lw, is_sw, is_beq, known, uses_rt, lu, bs, stl, taken;
        ex_t         nx;

        op     = instr[31:26];
        s      = instr[25:21];
        t      = instr[20:16];
        d      = instr[15:11];
        sx     = {{16{instr[15]}}, instr[15:0]};
        is_r   = (op == 6'h00);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_beq = (op == 6'h04);
        known  = is_r || is_lw || is_sw || is_beq;
        uses_rt = is_r || is_sw || is_beq;
        a      = mread(s);
        b      = mread(t);
        lu     = mex.m[1] && mex.wreg != 0 && (mex.wreg == s || (uses_rt && mex.wreg == t));
        bs     = is_beq && ((mex.wb[1] && mex.wreg != 0 && (mex.wreg == s || mex.wreg == t)) ||
                            (mem_rd_load && mem_wreg != 0 && (mem_wreg == s || mem_wreg == t)));
        stl    = in_valid && (lu || bs);
        taken  = in_valid && is_beq && !stl && !hold && (a == b);
        tgt    = pc_next + $unsigned($signed(sx) * 32'sd4);

        if (ok) begin
            chk("ex_valid", 64'(ex_valid), 64'(mex.valid));
            chk("ex_ctrl",  64'(ex_ctrl),  64'(mex.ctrl));
            chk("ex_m",     64'(ex_m),     64'(mex.m));
            chk("ex_wb",    64'(ex_wb),    64'(mex.wb));
            if (mex.valid) begin
                chk("ex_rs",    64'(ex_rs),    64'(mex.rs));
                chk("ex_rt",    64'(ex_rt),    64'(mex.rt));
                chk("ex_wreg",  64'(ex_wreg),  64'(mex.wreg));
                chk("ex_data1", 64'(ex_data1), 64'(mex.d1));
                chk("ex_data2", 64'(ex_data2), 64'(mex.d2));
                chk("ex_imm",   64'(ex_imm),   64'(mex.imm));
            end
            if (!rst) begin
                chk("pc_write",   64'(pc_write),   64'(!hold && !stl));
                chk("ifid_write", 64'(ifid_write), 64'(!hold && !stl));
                chk("br_taken",   64'(br_taken),   64'(taken));
                chk("br_target",  64'(br_target),  64'(tgt));
            end
        end

        if (rst) begin
            nx = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            ok = 1'b1;
        end else begin
            nx = mex;
            if (!hold) begin
                nx = '0;
                if (in_valid && !stl && known) begin
                    nx.valid = 1'b1;
                    nx.rs    = s;
                    nx.rt    = t;
                    nx.d1    = a;
                    nx.d2    = b;
                    nx.imm   = sx;
                    if (is_r)  begin nx.ctrl = 4'b1100; nx.wb = 2'b10; nx.wreg = d; end
                    if (is_lw) begin nx.ctrl = 4'b0001; nx.m = 2'b10; nx.wb = 2'b11; nx.wreg = t; end
                    if (is_sw) begin nx.ctrl = 4'b0001; nx.m = 2'b01; end
                end
            end
            if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
        end
        mex = nx;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 11'h020};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; in_valid = 1'b0; instr = 32'd0; pc_next = 32'd0; hold = 1'b0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; mem_rd_load = 1'b0; mem_wreg = 5'd0;
    endtask

    // Advance to just after the next rising edge with idle inputs.
    task automatic nxt();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Move to a point mid-cycle where all outputs are settled.
    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] beq_m1;
    logic [31:0] exp_sw;

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        peek();
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_wb", 64'(ex_wb), 64'd0);

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            nxt(); in_valid = 1'b1; instr = enc_r(5'(i), 5'(i), 5'd1);
            nxt();
            peek();
            chk("reg_zero_d1", 64'(ex_data1), 64'd0);
            chk("reg_zero_d2", 64'(ex_data2), 64'd0);
        end

        // Writeback then dependent R-type.
        nxt(); wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        nxt(); in_valid = 1'b1; instr = enc_r(5'd5, 5'd0, 5'd3); pc_next = 32'h104;
        nxt();
        peek();
        chk("add_data1", 64'(ex_data1), 64'h1234);
        chk("add_wreg",  64'(ex_wreg),  64'd3);
        chk("add_wb",    64'(ex_wb),    64'b10);
        chk("add_ctrl",  64'(ex_ctrl),  64'b1100);

        // Load-use: one stall cycle then the consumer goes.
        nxt(); in_valid = 1'b1; instr = enc_i(6'h23, 5'd1, 5'd2, 16'd4);
        nxt(); in_valid = 1'b1; instr = enc_r(5'd2, 5'd2, 5'd4);
        peek();
        chk("lu_pc_write",   64'(pc_write),   64'd0);
        chk("lu_ifid_write", 64'(ifid_write), 64'd0);
        nxt(); in_valid = 1'b1; instr = enc_r(5'd2, 5'd2, 5'd4);
        peek();
        chk("lu_bubble",  64'(ex_valid), 64'd0);
        chk("lu_release", 64'(pc_write), 64'd1);
        nxt();
        peek();
        chk("lu_add_valid", 64'(ex_valid), 64'd1);
        chk("lu_add_wreg",  64'(ex_wreg),  64'd4);

        // Load then beq on the loaded register: two stall cycles.
        beq_m1 = enc_i(6'h04, 5'd2, 5'd0, 16'hFFFF);
        nxt(); in_valid = 1'b1; instr = enc_i(6'h23, 5'd0, 5'd2, 16'd0);
        nxt(); in_valid = 1'b1; instr = beq_m1; pc_next = 32'h200;
        peek();
        chk("lb_stall1", 64'(pc_write), 64'd0);
        nxt(); in_valid = 1'b1; instr = beq_m1; pc_next = 32'h200;
        mem_rd_load = 1'b1; mem_wreg = 5'd2;
        peek();
        chk("lb_stall2", 64'(pc_write), 64'd0);
        chk("lb_nt2",    64'(br_taken), 64'd0);
        nxt(); in_valid = 1'b1; instr = beq_m1; pc_next = 32'h200;
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd0;
        peek();
        chk("lb_go",     64'(pc_write),  64'd1);
        chk("lb_taken",  64'(br_taken),  64'd1);
        chk("lb_target", 64'(br_target), 64'h1FC);

        // beq r1,r1,+3 resolves with no stall; under hold it is suppressed.
        nxt();
        nxt(); in_valid = 1'b1; instr = enc_i(6'h04, 5'd1, 5'd1, 16'd3); pc_next = 32'h100;
        peek();
        chk("beq_taken",  64'(br_taken),  64'd1);
        chk("beq_target", 64'(br_target), 64'h10C);
        chk("beq_nostall", 64'(pc_write), 64'd1);
        nxt(); in_valid = 1'b1; instr = enc_r(5'd5, 5'd0, 5'd3);
        nxt(); in_valid = 1'b1; instr = enc_i(6'h04, 5'd1, 5'd1, 16'd3); pc_next = 32'h100;
        hold = 1'b1;
        peek();
        chk("hold_nt", 64'(br_taken), 64'd0);
        chk("hold_pc", 64'(pc_write), 64'd0);
        nxt();
        peek();
        chk("hold_wreg",  64'(ex_wreg),  64'd3);
        chk("hold_ctrl",  64'(ex_ctrl),  64'b1100);
        chk("hold_data1", 64'(ex_data1), 64'h1234);

        // Same-cycle writeback against a store reading r7.
        nxt(); wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        nxt(); in_valid = 1'b1; instr = enc_i(6'h2B, 5'd0, 5'd7, 16'd0);
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
        nxt();
        peek();
`ifdef WB_BYPASS_EN
        exp_sw = 32'hAA;
`else
        exp_sw = 32'h55;
`endif
        chk("sw_data2", 64'(ex_data2), 64'(exp_sw));

        // Randomized traffic with a small register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            int k;
            logic [4:0] s, t, d;
            nxt();
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 9) != 0);
            s = 5'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) s = 5'($urandom_range(0, 31));
            k = int'($urandom_range(0, 9));
            if (k <= 2)      instr = enc_r(s, t, d);
            else if (k <= 4) instr = enc_i(6'h23, s, t, 16'($urandom));
            else if (k <= 6) instr = enc_i(6'h2B, s, t, 16'($urandom));
            else if (k <= 8) instr = enc_i(6'h04, s, t, 16'($urandom_range(0, 65535)));
            else             instr = $urandom;
            pc_next     = $urandom & 32'hFFFF_FFFC;
            hold        = ($urandom_range(0, 9) == 0);
            wb_we       = ($urandom_range(0, 1) == 1);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            mem_rd_load = ($urandom_range(0, 9) < 3);
            mem_wreg    = 5'($urandom_range(0, 7));
        end

        nxt();
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
